// File: rtl/mito_pkg.sv
// ----------------------------------------------------------------------------
// mito_pkg
// Purpose : shared types for the layer phase sequencer slice.
//   layer_t : layer kind presented by the layer controller.
//   phase_t : sequencer state, doubles as the externally visible phase code.
//   tile_limit() : number of output tiles for a given layer kind.
// ----------------------------------------------------------------------------
package mito_pkg;

    typedef enum logic [1:0] {
        NONE        = 2'b00,
        CONVOLUTION = 2'b01,
        POOLING     = 2'b10,
        FULLY       = 2'b11
    } layer_t;

    typedef enum logic [3:0] {
        IDLE    = 4'b0000,
        READ    = 4'b0100,
        COMP    = 4'b0101,
        WRITE   = 4'b0110,
        INIT    = 4'b0111,
        SUSPEND = 4'b1000,
        FINISH  = 4'b1001
    } phase_t;

    localparam int CNT_W = 9;

    // NONE never reaches INIT, so its value only needs to be harmless.
    function automatic logic [CNT_W-1:0] tile_limit(layer_t lt, int conv, int pool, int fc);
        logic [CNT_W-1:0] lim;
        case (lt)
            CONVOLUTION: lim = CNT_W'(conv);
            POOLING:     lim = CNT_W'(pool);
            FULLY:       lim = CNT_W'(fc);
            default:     lim = CNT_W'(1);
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/layer_phase_sequencer_if.sv
// ----------------------------------------------------------------------------
// layer_phase_sequencer_if
// Purpose : bundles the controller/memory/PE handshake of the sequencer.
//   master modport : layer controller + memory side (drives layer_type, stall,
//                    rd_ack, wr_ack; observes requests, tile_idx, phase,
//                    ofm_valid).
//   slave modport  : the sequencer itself.
// ----------------------------------------------------------------------------
interface layer_phase_sequencer_if import mito_pkg::*; ();

    layer_t       layer_type;
    logic         stall;
    logic         rd_req;
    logic         rd_ack;
    logic         comp_en;
    logic         wr_req;
    logic         wr_ack;
    logic [7:0]   tile_idx;
    phase_t       phase;
    logic         ofm_valid;

    modport master (
        output layer_type, stall, rd_ack, wr_ack,
        input  rd_req, comp_en, wr_req, tile_idx, phase, ofm_valid
    );

    modport slave (
        input  layer_type, stall, rd_ack, wr_ack,
        output rd_req, comp_en, wr_req, tile_idx, phase, ofm_valid
    );

endinterface

// File: rtl/layer_phase_sequencer_beat_counter.sv
// ----------------------------------------------------------------------------
// beat_counter
// Purpose : 9-bit up counter shared by the READ, COMP and WRITE phases.
//   clk, rst_n : clock, async active-low reset.
//   clear      : synchronous clear (wins over enable).
//   enable     : count one step.
//   compare    : value at which the current step is the final one.
//   last       : count equals compare.
// ----------------------------------------------------------------------------
module beat_counter import mito_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] compare,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == compare);

endmodule

// File: rtl/layer_phase_sequencer.sv
// ----------------------------------------------------------------------------
// layer_phase_sequencer
// Purpose : steps each output tile of a layer through READ -> COMP -> WRITE,
//           with suspend, abort and layer hand-over handling.
//   clk, rst_n : clock, async active-low reset.
//   bus        : slave side of layer_phase_sequencer_if (layer_type, stall,
//                rd_req/rd_ack, comp_en, wr_req/wr_ack, tile_idx, phase,
//                ofm_valid).
// ----------------------------------------------------------------------------
module layer_phase_sequencer import mito_pkg::*; #(
    parameter int CONV_TILES  = 4,
    parameter int POOL_TILES  = 2,
    parameter int FC_TILES    = 1,
    parameter int RD_BEATS    = 4,
    parameter int COMP_CYCLES = 3,
    parameter int WR_BEATS    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    layer_phase_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(RD_BEATS - 1);
    localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(COMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(WR_BEATS - 1);

    phase_t           state_q, state_d;
    phase_t           ret_q, ret_d;
    layer_t           cur_layer_q, cur_layer_d;
    logic [7:0]       tile_q, tile_d;
    logic [CNT_W-1:0] limit_q, limit_d;

    logic             cnt_clear;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_cmp;
    logic             cnt_last;
    phase_t           adv;

    beat_counter u_beat_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .compare (cnt_cmp),
        .last    (cnt_last)
    );

    // The one counter is reused; its terminal value depends on the phase.
    always_comb begin
        cnt_cmp = '0;
        case (state_q)
            READ:    cnt_cmp = RD_LAST;
            COMP:    cnt_cmp = COMP_LAST;
            WRITE:   cnt_cmp = WR_LAST;
            default: cnt_cmp = '0;
        endcase
    end

    // Next-state logic. For the working phases the natural successor is
    // computed into adv first, so a stall can park it as the return state
    // while the beat of that same cycle is still counted.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        cur_layer_d = cur_layer_q;
        tile_d      = tile_q;
        limit_d     = limit_q;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        adv         = state_q;

        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                tile_d    = '0;
                if (bus.layer_type != NONE) begin
                    cur_layer_d = bus.layer_type;
                    state_d     = INIT;
                end
            end
            INIT: begin
                limit_d   = tile_limit(cur_layer_q, CONV_TILES, POOL_TILES, FC_TILES);
                tile_d    = '0;
                cnt_clear = 1'b1;
                state_d   = READ;
            end
            READ: begin
                if (bus.rd_ack) begin
                    if (cnt_last) begin
                        cnt_clear = 1'b1;
                        adv       = COMP;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            COMP: begin
                if (cnt_last) begin
                    cnt_clear = 1'b1;
                    adv       = WRITE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            WRITE: begin
                if (bus.wr_ack) begin
                    if (cnt_last) begin
                        cnt_clear = 1'b1;
                        if ({1'b0, tile_q} == limit_q - CNT_W'(1)) begin
                            adv = FINISH;
                        end else begin
                            tile_d = tile_q + 8'd1;
                            adv    = READ;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            SUSPEND: begin
                if (!bus.stall) begin
                    state_d = ret_q;
                end
            end
            FINISH: begin
                if (bus.layer_type == NONE) begin
                    state_d = IDLE;
                end else if (bus.layer_type != cur_layer_q) begin
                    cur_layer_d = bus.layer_type;
                    tile_d      = '0;
                    cnt_clear   = 1'b1;
                    state_d     = INIT;
                end
            end
            default: begin
                cnt_clear = 1'b1;
                tile_d    = '0;
                state_d   = IDLE;
            end
        endcase

        if (state_q == READ || state_q == COMP || state_q == WRITE) begin
            if (bus.stall) begin
                ret_d   = adv;
                state_d = SUSPEND;
            end else begin
                state_d = adv;
            end
        end

        // Dropping to NONE mid-layer abandons the layer outright.
        if ((state_q == INIT || state_q == READ || state_q == COMP ||
             state_q == WRITE || state_q == SUSPEND) && bus.layer_type == NONE) begin
            state_d     = IDLE;
            cnt_clear   = 1'b1;
            cnt_en      = 1'b0;
            tile_d      = '0;
            cur_layer_d = NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            cur_layer_q <= NONE;
            tile_q      <= '0;
            limit_q     <= CNT_W'(1);
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            cur_layer_q <= cur_layer_d;
            tile_q      <= tile_d;
            limit_q     <= limit_d;
        end
    end

    assign bus.rd_req    = (state_q == READ);
    assign bus.comp_en   = (state_q == COMP);
    assign bus.wr_req    = (state_q == WRITE);
    assign bus.tile_idx  = tile_q;
    assign bus.phase     = state_q;
    // Comparing against the live layer_type drops ofm_valid in the very
    // cycle the controller moves on, so it never overlaps the next layer.
    assign bus.ofm_valid = (state_q == FINISH) && (bus.layer_type == cur_layer_q);

endmodule

// File: tb/tb_layer_phase_sequencer.sv
// ----------------------------------------------------------------------------
// tb_layer_phase_sequencer
// Purpose : self-checking bench for layer_phase_sequencer (default params).
//   Each table row is one clock cycle: the inputs driven in that cycle and
//   the phase/tile/ofm_valid expected in that same cycle. Requests are
//   expected to follow the phase (rd_req in READ, comp_en in COMP, wr_req in
//   WRITE, all else 0).
// ----------------------------------------------------------------------------
module tb_layer_phase_sequencer;
    import mito_pkg::*;

    typedef struct {
        layer_t     lt;
        logic       stall;
        logic       rd_ack;
        logic       wr_ack;
        phase_t     ph;
        logic [7:0] tile;
        logic       ofm;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    layer_phase_sequencer_if bus ();

    layer_phase_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic vec_t mk(layer_t lt, logic st, logic ra, logic wa,
                                phase_t ph, logic [7:0] tile, logic ofm);
        vec_t v;
        v.lt = lt; v.stall = st; v.rd_ack = ra; v.wr_ack = wa;
        v.ph = ph; v.tile = tile; v.ofm = ofm;
        return v;
    endfunction

    function automatic void addVec(layer_t lt, logic st, logic ra, logic wa,
                                   phase_t ph, logic [7:0] tile, logic ofm);
        vecs.push_back(mk(lt, st, ra, wa, ph, tile, ofm));
    endfunction

    // One undisturbed tile: 4 read beats, 3 compute cycles, 2 write beats.
    function automatic void addTile(layer_t lt, logic [7:0] tile);
        for (int i = 0; i < 4; i++) addVec(lt, 1'b0, 1'b1, 1'b1, READ, tile, 1'b0);
        for (int i = 0; i < 3; i++) addVec(lt, 1'b0, 1'b1, 1'b1, COMP, tile, 1'b0);
        for (int i = 0; i < 2; i++) addVec(lt, 1'b0, 1'b1, 1'b1, WRITE, tile, 1'b0);
    endfunction

    function automatic void compare(string name, int act, int req);
        checks++;
        if (act == req) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.layer_type = v.lt;
        bus.stall      = v.stall;
        bus.rd_ack     = v.rd_ack;
        bus.wr_ack     = v.wr_ack;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL %s: scoreboard empty, got phase %0d, expected an entry", tag, bus.phase);
            return;
        end
        e = exp_q.pop_front();
        compare({tag, ".phase"},     bus.phase,     e.ph);
        compare({tag, ".tile_idx"},  bus.tile_idx,  e.tile);
        compare({tag, ".ofm_valid"}, bus.ofm_valid, e.ofm);
        compare({tag, ".rd_req"},    bus.rd_req,    (e.ph == READ));
        compare({tag, ".comp_en"},   bus.comp_en,   (e.ph == COMP));
        compare({tag, ".wr_req"},    bus.wr_req,    (e.ph == WRITE));
    endtask

    task automatic runVecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            #3;
            checkOutput($sformatf("%s[%0d]", tag, i));
        end
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus.layer_type = NONE;
        bus.stall      = 1'b0;
        bus.rd_ack     = 1'b0;
        bus.wr_ack     = 1'b0;

        #12;
        applyStimulus(mk(NONE, 1'b0, 1'b0, 1'b0, IDLE, 8'd0, 1'b0));
        checkOutput("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Convolution layer start to finish, then hand-over to pooling.
        addVec(CONVOLUTION, 1'b0, 1'b1, 1'b1, IDLE, 8'd0, 1'b0);
        addVec(CONVOLUTION, 1'b0, 1'b1, 1'b1, INIT, 8'd0, 1'b0);
        for (int t = 0; t < 4; t++) addTile(CONVOLUTION, 8'(t));
        for (int i = 0; i < 10; i++) addVec(CONVOLUTION, 1'b0, 1'b1, 1'b1, FINISH, 8'd3, 1'b1);
        addVec(POOLING, 1'b0, 1'b1, 1'b1, FINISH, 8'd3, 1'b0);
        addVec(POOLING, 1'b0, 1'b1, 1'b1, INIT, 8'd0, 1'b0);

        // Pooling tile 0: throttled reads, then a 5-cycle stall mid-compute.
        for (int i = 0; i < 7; i++) addVec(POOLING, 1'b0, (i % 2 == 0), 1'b1, READ, 8'd0, 1'b0);
        addVec(POOLING, 1'b0, 1'b1, 1'b1, COMP, 8'd0, 1'b0);
        addVec(POOLING, 1'b1, 1'b1, 1'b1, COMP, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) addVec(POOLING, 1'b1, 1'b1, 1'b1, SUSPEND, 8'd0, 1'b0);
        addVec(POOLING, 1'b0, 1'b1, 1'b1, SUSPEND, 8'd0, 1'b0);
        addVec(POOLING, 1'b0, 1'b1, 1'b1, COMP, 8'd0, 1'b0);
        addVec(POOLING, 1'b0, 1'b1, 1'b1, WRITE, 8'd0, 1'b0);
        addVec(POOLING, 1'b0, 1'b1, 1'b1, WRITE, 8'd0, 1'b0);
        addTile(POOLING, 8'd1);
        addVec(POOLING, 1'b0, 1'b1, 1'b1, FINISH, 8'd1, 1'b1);
        addVec(POOLING, 1'b0, 1'b1, 1'b1, FINISH, 8'd1, 1'b1);

        // New convolution layer aborted during WRITE of tile 2.
        addVec(CONVOLUTION, 1'b0, 1'b1, 1'b1, FINISH, 8'd1, 1'b0);
        addVec(CONVOLUTION, 1'b0, 1'b1, 1'b1, INIT, 8'd0, 1'b0);
        addTile(CONVOLUTION, 8'd0);
        addTile(CONVOLUTION, 8'd1);
        for (int i = 0; i < 4; i++) addVec(CONVOLUTION, 1'b0, 1'b1, 1'b1, READ, 8'd2, 1'b0);
        for (int i = 0; i < 3; i++) addVec(CONVOLUTION, 1'b0, 1'b1, 1'b1, COMP, 8'd2, 1'b0);
        addVec(NONE, 1'b0, 1'b1, 1'b1, WRITE, 8'd2, 1'b0);
        for (int i = 0; i < 3; i++) addVec(NONE, 1'b0, 1'b1, 1'b1, IDLE, 8'd0, 1'b0);
        runVecs("main");

        // Run into READ of tile 1, then pull reset between clock edges.
        addVec(CONVOLUTION, 1'b0, 1'b1, 1'b1, IDLE, 8'd0, 1'b0);
        addVec(CONVOLUTION, 1'b0, 1'b1, 1'b1, INIT, 8'd0, 1'b0);
        addTile(CONVOLUTION, 8'd0);
        addVec(CONVOLUTION, 1'b0, 1'b1, 1'b1, READ, 8'd1, 1'b0);
        addVec(CONVOLUTION, 1'b0, 1'b1, 1'b1, READ, 8'd1, 1'b0);
        runVecs("pre_rst");

        @(posedge clk);
        #1;
        applyStimulus(mk(CONVOLUTION, 1'b0, 1'b1, 1'b1, IDLE, 8'd0, 1'b0));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async");

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(mk(FULLY, 1'b0, 1'b1, 1'b1, IDLE, 8'd0, 1'b0));
        #3;
        checkOutput("rst_release");

        // Single-tile fully-connected layer, then release to NONE.
        addVec(FULLY, 1'b0, 1'b1, 1'b1, INIT, 8'd0, 1'b0);
        addTile(FULLY, 8'd0);
        for (int i = 0; i < 3; i++) addVec(FULLY, 1'b0, 1'b1, 1'b1, FINISH, 8'd0, 1'b1);
        addVec(NONE, 1'b0, 1'b1, 1'b1, FINISH, 8'd0, 1'b0);
        addVec(NONE, 1'b0, 1'b1, 1'b1, IDLE, 8'd0, 1'b0);
        runVecs("fc");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/layer_phase_sequencer.md
LAYER_PHASE_SEQUENCER -- requirements
Module: layer_phase_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CONV_TILES, 4: output tiles per convolution layer.
- POOL_TILES, 2: output tiles per pooling layer.
- FC_TILES, 1: output tiles per fully-connected layer.
- RD_BEATS, 4: read beats per tile.
- COMP_CYCLES, 3: compute cycles per tile.
- WR_BEATS, 2: write beats per tile.
- All parameters are at least 1 and at most 256.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- layer_type, in, 2: current layer from the layer controller (NONE=00, CONVOLUTION=01, POOLING=10, FULLY=11).
- stall, in, 1: suspend request.
- rd_req, out, 1: ifm/weight read request.
- rd_ack, in, 1: read beat accepted.
- comp_en, out, 1: PE array enable.
- wr_req, out, 1: ofm write request.
- wr_ack, in, 1: write beat accepted.
- tile_idx, out, 8: index of the current tile.
- phase, out, 4: current state encoding.
- ofm_valid, out, 1: layer output complete; returned to the layer controller.

Function
REQ-003 The sequencer SHALL have these states and phase encodings: IDLE=0000, READ=0100, COMP=0101, WRITE=0110, INIT=0111, SUSPEND=1000, FINISH=1001.
REQ-004 IDLE SHALL move to INIT when layer_type != NONE, latching layer_type into cur_layer.
REQ-005 INIT SHALL last exactly one cycle.
- Loads the tile limit for cur_layer.
- Clears tile_idx and the beat counter.
- Moves to READ.
REQ-006 READ SHALL behave as follows.
- rd_req=1.
- Each cycle with rd_ack=1 counts one beat.
- The ack of beat RD_BEATS moves the block to COMP and clears the counter.
REQ-007 COMP SHALL hold comp_en=1 for exactly COMP_CYCLES cycles, then move to WRITE.
REQ-008 WRITE SHALL behave as follows.
- wr_req=1.
- The ack of beat WR_BEATS moves the block to FINISH if tile_idx == limit-1.
- Otherwise it increments tile_idx and moves to READ.
REQ-009 rd_req, comp_en and wr_req SHALL be decoded from state only and SHALL be mutually exclusive.
REQ-010 stall=1 sampled in READ, COMP or WRITE SHALL move the block to SUSPEND next cycle.
- A beat acked in that same cycle is still counted.
- The return state saved is the state that would otherwise have been next.
REQ-011 SUSPEND SHALL behave as follows.
- All requests and comp_en are 0.
- Counters and tile_idx are frozen.
- stall=0 returns the block to the saved state next cycle.
- stall is ignored in IDLE, INIT and FINISH.
REQ-012 ofm_valid SHALL be combinational: (state == FINISH) && (layer_type == cur_layer).
- It stays high until the controller changes layer_type.
- It never overlaps a new layer.
REQ-013 FINISH SHALL exit as follows.
- layer_type == NONE moves to IDLE.
- Any other value != cur_layer moves to INIT, latching the new layer.
- An unchanged layer_type holds FINISH.
REQ-014 layer_type == NONE in any state other than IDLE or FINISH SHALL abort the layer: IDLE next cycle, counters cleared.
REQ-015 Any other layer_type change before FINISH SHALL be ignored.
REQ-016 Beat and cycle counters SHALL be 9 bits wide.
REQ-017 Tile limit selection SHALL be: 01 uses CONV_TILES, 10 uses POOL_TILES, 11 uses FC_TILES.
REQ-018 Unused state encodings SHALL return the block to IDLE next cycle.

Reset
REQ-019 rst_n low SHALL asynchronously force the following, including mid-layer or mid-suspend.
- state=IDLE, phase=0000.
- tile_idx=0, counters=0, cur_layer=NONE.
- ofm_valid=0, rd_req=0, comp_en=0, wr_req=0.
REQ-020 After rst_n deasserts, the first transition SHALL occur on the first rising clk edge.

Structure
REQ-021 The shared package mito_pkg SHALL hold:
- the layer_type enum (NONE, CONVOLUTION, POOLING, FULLY);
- the phase enum (IDLE, READ, COMP, WRITE, INIT, SUSPEND, FINISH) with the encodings of REQ-003.
REQ-022 One sub-module, beat_counter, SHALL provide the 9-bit counter.
- Inputs: clear, enable.
- Output: last flag against a compare input.
- Instantiated once and reused across READ, COMP and WRITE.

Verification
REQ-023 Run these directed scenarios.
- Defaults, rd_ack=wr_ack=1, stall=0, layer_type 00→01 at cycle 0.
  - Phase sequence: INIT in cycle 1, then 4 tiles of READ(4)/COMP(3)/WRITE(2).
  - ofm_valid first high in cycle 38; tile_idx steps 0,1,2,3.
- In FINISH with layer_type held at 01: ofm_valid stays 1 for 10 cycles. Then layer_type=10: ofm_valid is 0 in that same cycle, and INIT follows next cycle.
- rd_ack toggles 1,0,1,0… in READ: rd_req is held for 7 cycles before COMP; exactly 4 beats are counted.
- stall=1 for 5 cycles at COMP cycle 2: SUSPEND for 5 cycles with comp_en=0, then COMP resumes with exactly 1 cycle remaining.
- layer_type=00 during WRITE of tile 2: IDLE next cycle, tile_idx=0, ofm_valid never asserted.
- rst_n low in READ of tile 1: all outputs are 0 immediately. After release with layer_type=11: 1 FC tile, then FINISH.
